// File: rtl/latch_service.sv
// latch_service: services sticky upstream request latches one channel at a time.
// A winning channel is granted for HOLD_CYCLES cycles and then gets a one-cycle
// clear pulse. The FSM then waits until that latch reads back low before it
// arbitrates again.
// Optional feature: define LATCH_SERVICE_RR_EN for round-robin arbitration.
// The default build uses fixed priority, where the lowest pending index wins.
module latch_service #(
   parameter int N           = 4,
   parameter int HOLD_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [N-1:0] clr,
   output logic         busy,
   output logic [7:0]   svc_count
);

   localparam int IW = $clog2(N);
   localparam logic [7:0] LAST_HOLD = 8'(HOLD_CYCLES - 1);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SERVE, CLEAR, DRAIN} state_t;

   state_t        state;
   state_t        next_state;
   logic [IW-1:0] sel;
   logic [IW-1:0] sel_next;
   logic [IW-1:0] pick;
   logic [7:0]    hold_cnt;
   logic [N-1:0]  grant_next;
   logic [N-1:0]  clr_next;
   logic          busy_next;

`ifdef LATCH_SERVICE_RR_EN
   logic [IW-1:0] ptr;
   int            rr_idx;
   logic          rr_found;

   // Round-robin pick: first pending channel at or after the pointer
   always_comb begin
      pick     = '0;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int k = 0; k < N; k++) begin
         rr_idx = (int'(ptr) + k) % N;
         if (!rr_found && req[rr_idx]) begin
            pick     = IW'(rr_idx);
            rr_found = 1'b1;
         end
      end
   end

   // Pointer moves just past the channel being cleared
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (state == CLEAR) begin
         ptr <= (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
      end
   end
`else
   // Fixed priority pick: lowest-numbered pending channel wins
   always_comb begin
      pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            pick = IW'(i);
         end
      end
   end
`endif

   // State register, selection register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         grant <= '0;
         clr   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         sel   <= sel_next;
         grant <= grant_next;
         clr   <= clr_next;
         busy  <= busy_next;
      end
   end

   // Hold counter and completed-service counter
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt  <= '0;
         svc_count <= '0;
      end else begin
         if (state == SERVE && next_state == SERVE) begin
            hold_cnt <= hold_cnt + 8'd1;
         end else begin
            hold_cnt <= '0;
         end
         if (next_state == CLEAR) begin
            svc_count <= svc_count + 8'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req != '0) next_state = SERVE;
         SERVE:   if (hold_cnt == LAST_HOLD) next_state = CLEAR;
         CLEAR:   next_state = DRAIN;
         DRAIN:   if (!req[sel]) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output is a flop
   always_comb begin
      sel_next   = (state == IDLE) ? pick : sel;
      grant_next = (next_state == SERVE) ? (ONE << sel_next) : '0;
      clr_next   = (next_state == CLEAR) ? (ONE << sel) : '0;
      busy_next  = (next_state != IDLE);
   end

endmodule

// File: tb/tb_latch_service.sv
// tb_latch_service: randomized and directed bench for latch_service with a
// timeline-based reference model (service age relative to acceptance).
module tb_latch_service;

   localparam int N = 4;
   localparam int H = 4;
`ifdef LATCH_SERVICE_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant;
   logic [N-1:0] clr;
   logic         busy;
   logic [7:0]   svc_count;

   int errors = 0;
   int checks = 0;

   bit m_active = 1'b0;
   int m_sel    = 0;
   int m_age    = 0;
   int m_count  = 0;
   int m_ptr    = 0;

   logic [N-1:0] lat      = '0;
   logic [N-1:0] last_clr = '0;

   latch_service #(.N(N), .HOLD_CYCLES(H)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant),
      .clr(clr), .busy(busy), .svc_count(svc_count)
   );

   always #5 clk = ~clk;

   function automatic int model_pick(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return 0;
   endfunction

   function automatic logic [N-1:0] exp_grant();
      logic [N-1:0] one;
      one = 1;
      return (m_active && m_age <= H) ? (one << m_sel) : '0;
   endfunction

   function automatic logic [N-1:0] exp_clr();
      logic [N-1:0] one;
      one = 1;
      return (m_active && m_age == H + 1) ? (one << m_sel) : '0;
   endfunction

   task automatic step();
      @(posedge clk);
      if (rst) begin
         m_active = 1'b0;
         m_age    = 0;
         m_count  = 0;
         m_ptr    = 0;
      end else if (!m_active) begin
         if (req != '0) begin
            m_active = 1'b1;
            m_sel    = model_pick(req, RR ? m_ptr : 0);
            m_age    = 1;
         end
      end else if (m_age >= H + 2 && !req[m_sel]) begin
         m_active = 1'b0;
      end else begin
         m_age++;
         if (m_age == H + 1) begin
            m_count++;
            m_ptr = (m_sel + 1) % N;
         end
      end
      #1;
   endtask

   task automatic drive_latch(input logic [N-1:0] sets);
      lat      = (lat & ~last_clr) | sets;
      last_clr = clr;
      req      = lat;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; lat = '0; last_clr = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111;
      step();
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (clr !== 4'b0000) begin errors++; $display("[TB] FAIL reset_clr: got %b want 0000", clr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (svc_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_svc: got %0d want 0", svc_count); end
      rst = 1'b0; req = '0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      do_reset();
      req = 4'b0001;
      step();
      for (int c = 1; c <= H; c++) begin
         checks++;
         if (grant !== 4'b0001 || clr !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_grant c%0d: grant=%b clr=%b busy=%b want 0001/0000/1", c, grant, clr, busy);
         end
         if (c < H) step();
      end
      step();
      checks++;
      if (clr !== 4'b0001 || grant !== 4'b0000 || svc_count !== 8'd1) begin
         errors++;
         $display("[TB] FAIL basic_clear: clr=%b grant=%b svc=%0d want 0001/0000/1", clr, grant, svc_count);
      end
      step();
      checks++;
      if (busy !== 1'b1 || clr !== 4'b0000) begin
         errors++; $display("[TB] FAIL basic_drain: busy=%b clr=%b want 1/0000", busy, clr);
      end
      req = '0;
      step();
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
         errors++; $display("[TB] FAIL basic_idle: busy=%b grant=%b want 0/0000", busy, grant);
      end
   endtask

   task automatic test_reset_mid_serve();
      do_reset();
      req = 4'b0001;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || clr !== 4'b0000 || svc_count !== 8'd0) begin
         errors++;
         $display("[TB] FAIL midreset_abort: grant=%b busy=%b clr=%b svc=%0d want 0000/0/0000/0", grant, busy, clr, svc_count);
      end
      step();
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL midreset_restart: grant=%b busy=%b want 0001/1", grant, busy);
      end
      lat = req; last_clr = '0;
      for (int c = 0; c < 40 && m_active; c++) begin
         drive_latch('0);
         step();
         checks++;
         if (grant !== exp_grant() || clr !== exp_clr()) begin
            errors++;
            $display("[TB] FAIL midreset_finish: grant=%b clr=%b want %b/%b", grant, clr, exp_grant(), exp_clr());
         end
      end
      checks++; if (m_active) begin errors++; $display("[TB] FAIL midreset_timeout: service did not complete"); end
   endtask

   task automatic test_stuck();
      do_reset();
      req = 4'b0010;
      for (int c = 0; c <= H; c++) step();
      checks++;
      if (clr !== 4'b0010) begin errors++; $display("[TB] FAIL stuck_clr: got %b want 0010", clr); end
      for (int c = 0; c < 20; c++) begin
         step();
         checks++;
         if (busy !== 1'b1 || clr !== 4'b0000 || grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stuck_drain c%0d: busy=%b clr=%b grant=%b want 1/0000/0000", c, busy, clr, grant);
         end
      end
      req = '0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stuck_release: busy=%b want 0", busy); end
   endtask

   task automatic test_order();
      logic [N-1:0] expv [5];
      logic [N-1:0] prev_grant;
      int got;
      if (RR) expv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      else    expv = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      do_reset();
      lat = '1; last_clr = '0; req = lat;
      got = 0; prev_grant = '0;
      for (int c = 0; c < 300 && got < 5; c++) begin
         step();
         if (grant != '0 && prev_grant == '0) begin
            checks++;
            if (grant !== expv[got]) begin
               errors++; $display("[TB] FAIL order_%0d: grant=%b want %b", got, grant, expv[got]);
            end
            got++;
         end
         prev_grant = grant;
         drive_latch(~lat);
      end
      checks++; if (got != 5) begin errors++; $display("[TB] FAIL order_timeout: services=%0d want 5", got); end
   endtask

   task automatic test_other_channel();
      logic [N-1:0] expv [2];
      logic [N-1:0] prev_grant;
      int got;
      expv = '{4'b0001, 4'b0100};
      do_reset();
      lat = 4'b0001; last_clr = '0; req = lat;
      got = 0; prev_grant = '0;
      for (int c = 0; c < 200 && got < 2; c++) begin
         step();
         if (grant != '0 && prev_grant == '0) begin
            checks++;
            if (grant !== expv[got]) begin
               errors++; $display("[TB] FAIL other_%0d: grant=%b want %b", got, grant, expv[got]);
            end
            got++;
         end
         prev_grant = grant;
         drive_latch((c == 2) ? 4'b0100 : 4'b0000);
      end
      checks++; if (got != 2) begin errors++; $display("[TB] FAIL other_timeout: services=%0d want 2", got); end
   endtask

   task automatic test_wrap();
      do_reset();
      lat = '0; last_clr = '0;
      for (int c = 0; c < 256 * 10 && m_count < 256; c++) begin
         drive_latch((lat == '0) ? 4'b0001 : 4'b0000);
         step();
         checks++;
         if ((grant & clr) !== 4'b0000 || clr !== exp_clr()) begin
            errors++; $display("[TB] FAIL wrap_cycle: grant=%b clr=%b want clr %b", grant, clr, exp_clr());
         end
      end
      checks++; if (m_count != 256) begin errors++; $display("[TB] FAIL wrap_timeout: services=%0d want 256", m_count); end
      checks++; if (svc_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_count: got %0d want 0", svc_count); end
   endtask

   task automatic test_random();
      logic [N-1:0] sets;
      do_reset();
      lat = '0; last_clr = '0;
      for (int c = 0; c < 3000; c++) begin
         sets = '0;
         if ($urandom_range(0, 3) == 0) sets[$urandom_range(0, N - 1)] = 1'b1;
         if ($urandom_range(0, 15) == 0) lat[$urandom_range(0, N - 1)] = 1'b0;
         rst = ($urandom_range(0, 199) == 0);
         drive_latch(sets);
         step();
         checks++;
         if (grant !== exp_grant() || clr !== exp_clr() || busy !== m_active || svc_count !== 8'(m_count)) begin
            errors++;
            $display("[TB] FAIL random c%0d: grant=%b clr=%b busy=%b svc=%0d want %b/%b/%b/%0d",
                     c, grant, clr, busy, svc_count, exp_grant(), exp_clr(), m_active, 8'(m_count));
         end
         checks++;
         if ((grant & clr) !== 4'b0000) begin
            errors++; $display("[TB] FAIL random_overlap c%0d: grant=%b clr=%b", c, grant, clr);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      $display("[TB] latch_service bench, RR=%0d", RR);
      test_reset();
      test_basic();
      test_reset_mid_serve();
      test_stuck();
      test_order();
      test_other_channel();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
